frv_mem_req_queue: RTL and testbench

Parametrised memory stage for the frv pipeline. It accepts load/store micro-ops from stage 3 and issues them to the data bus or the MMIO port. It tracks up to DEPTH granted-but-unanswered dmem transactions and hands completed results, with formatted load data or a trap, to stage 4 strictly in program order. It succeeds the single-outstanding memory stage by adding pipelined bus requests, response handling, in-order completion, and flush of in-flight transactions.

---
 rtl/frv_mem_req_queue_pkg.sv | 42 ++++
 rtl/frv_mem_fifo.sv | 56 +++++
 rtl/frv_mem_req_queue.sv | 210 +++++++++++++++++++++
 tb/tb_frv_mem_req_queue.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_req_queue_pkg.sv
// frv memory stage shared types:
// trap causes, LSU size codes and queue entry layout.
package frv_mem_req_queue_pkg;

  localparam logic [4:0] TRAP_LDALIGN  = 5'd4;
  localparam logic [4:0] TRAP_LDACCESS = 5'd5;
  localparam logic [4:0] TRAP_STALIGN  = 5'd6;
  localparam logic [4:0] TRAP_STACCESS = 5'd7;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        load;
    logic [1:0]  sz;
    logic        sgn;
    logic [1:0]  lo;
    logic        done;
    logic        trap;
    logic        killed;
    logic [31:0] data;
  } lsu_ent_t;

  localparam int ENT_W    = $bits(lsu_ent_t);
  localparam int KILL_BIT = 32;
  localparam int DONE_BIT = 34;

  function automatic logic [4:0] trap_cause(
    input logic load,
    input logic access
  );
    logic [4:0] c;
    if (load) c = access ? TRAP_LDACCESS : TRAP_LDALIGN;
    else      c = access ? TRAP_STACCESS : TRAP_STALIGN;
    return c;
  endfunction

endpackage

// File: rtl/frv_mem_fifo.sv
// Pointer-based FIFO with a random-access update port
// and a one-shot kill of every stored entry.
module frv_mem_fifo #(
  parameter int DEPTH    = 2,
  parameter int W        = 8,
  parameter int KILL_BIT = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      g_clk,
  input  logic                      g_resetn,
  input  logic                      i_push,
  input  logic [W-1:0]              i_din,
  input  logic                      i_pop,
  input  logic                      i_upd_en,
  input  logic [AW-1:0]             i_upd_idx,
  input  logic [W-1:0]              i_upd_data,
  input  logic                      i_kill_all,
  output logic [DEPTH-1:0][W-1:0]   o_ents,
  output logic [AW:0]               o_rptr,
  output logic [AW:0]               o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;
  logic [DEPTH-1:0][W-1:0] r_mem;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Kill is applied after the update so a same-cycle response stays killed
  always_ff @(posedge g_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_upd_en && i_upd_idx == AW'(i))
        r_mem[i] <= i_upd_data;
      if (i_kill_all)
        r_mem[i][KILL_BIT] <= 1'b1;
    end
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_ents  = r_mem;
  assign o_rptr  = r_rptr;
  assign o_count = r_wptr - r_rptr;
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (r_wptr == r_rptr);

endmodule

// File: rtl/frv_mem_req_queue.sv
// frv memory stage: pipelined dmem/MMIO issue with
// in-order completion of up to DEPTH outstanding ops.
module frv_mem_req_queue
  import frv_mem_req_queue_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          DEPTH          = 2,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            hold_lsu_req,
  input  logic            s3_valid,
  output logic            s3_busy,
  input  logic [4:0]      s3_rd,
  input  logic [XLEN-1:0] s3_addr,
  input  logic [XLEN-1:0] s3_wdata,
  input  logic            s3_load,
  input  logic            s3_store,
  input  logic [1:0]      s3_size,
  input  logic            s3_signed,
  output logic            dmem_req,
  output logic            dmem_wen,
  output logic [3:0]      dmem_strb,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_recv,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_error,
  output logic            mmio_en,
  output logic            mmio_wen,
  output logic [31:0]     mmio_addr,
  output logic [31:0]     mmio_wdata,
  output logic            s4_valid,
  input  logic            s4_busy,
  output logic [4:0]      s4_rd,
  output logic            s4_trap,
  output logic [XLEN-1:0] s4_data
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]                  w_lo;
  logic                        w_mis;
  logic                        w_mmio;
  logic                        w_mem;
  logic                        w_bus;
  logic                        w_free;
  logic                        w_acc;
  logic                        w_pop;
  logic [3:0]                  w_strb;
  logic [31:0]                 w_wdata;
  lsu_ent_t                    w_din;
  lsu_ent_t                    w_head;
  lsu_ent_t                    w_pend_ent;
  lsu_ent_t                    w_upd;
  logic                        w_pend_ok;
  logic [AW-1:0]               w_pend_idx;
  logic [DEPTH-1:0][ENT_W-1:0] w_ents;
  logic [AW:0]                 w_rptr;
  logic [AW:0]                 w_count;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_unused;

  function automatic logic [31:0] fmt_load(
    input logic [31:0] d,
    input logic [1:0]  lo,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {lo, 3'b000};
    r = s;
    unique case (1'b1)
      (sz == LSU_BYTE): r = {{24{sg & s[7]}}, s[7:0]};
      (sz == LSU_HALF): r = {{16{sg & s[15]}}, s[15:0]};
      default:          r = s;
    endcase
    return r;
  endfunction

  assign w_lo  = s3_addr[1:0];
  assign w_mis = (s3_size == LSU_HALF && w_lo[0])
              || (s3_size[1] && w_lo != 2'b00);
  assign w_mmio = !w_mis
    && ((s3_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
  assign w_mem  = s3_load | s3_store;
  assign w_bus  = w_mem && !w_mis && !w_mmio;
  // A same-cycle pop frees the slot for an incoming op
  assign w_free = !w_full || w_pop;

  assign dmem_req = s3_valid && w_bus && w_free
                 && !hold_lsu_req && !flush;
  assign s3_busy  = !w_free
                 || (w_bus && !(dmem_req && dmem_gnt))
                 || hold_lsu_req || flush;
  assign w_acc    = s3_valid && !s3_busy && w_mem;

  always_comb begin
    w_strb  = 4'hF;
    w_wdata = s3_wdata;
    unique case (1'b1)
      (s3_size == LSU_BYTE): begin
        w_strb  = 4'b0001 << w_lo;
        w_wdata = {4{s3_wdata[7:0]}};
      end
      (s3_size == LSU_HALF): begin
        w_strb  = 4'b0011 << w_lo;
        w_wdata = {2{s3_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_wen   = s3_store;
  assign dmem_strb  = w_strb;
  assign dmem_addr  = {s3_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata = w_wdata;

  assign mmio_en    = w_acc && w_mmio;
  assign mmio_wen   = mmio_en && s3_store;
  assign mmio_addr  = s3_addr;
  assign mmio_wdata = s3_wdata;

  always_comb begin
    w_din      = '0;
    w_din.rd   = w_mis ? trap_cause(s3_load, 1'b0) : s3_rd;
    w_din.load = s3_load;
    w_din.sz   = s3_size;
    w_din.sgn  = s3_signed;
    w_din.lo   = w_lo;
    w_din.done = !w_bus;
    w_din.trap = w_mis;
  end

  // Oldest occupied entry still waiting on the bus
  always_comb begin
    logic [AW-1:0] k;
    k          = '0;
    w_pend_ok  = 1'b0;
    w_pend_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      k = w_rptr[AW-1:0] + AW'(i);
      if ((AW+1)'(i) < w_count && !w_ents[k][DONE_BIT]) begin
        w_pend_ok  = 1'b1;
        w_pend_idx = k;
      end
    end
  end

  assign w_pend_ent = lsu_ent_t'(w_ents[w_pend_idx]);

  always_comb begin
    w_upd      = w_pend_ent;
    w_upd.done = 1'b1;
    w_upd.data = w_pend_ent.load
      ? fmt_load(dmem_rdata, w_pend_ent.lo,
                 w_pend_ent.sz, w_pend_ent.sgn)
      : '0;
    if (dmem_error) begin
      w_upd.trap = 1'b1;
      w_upd.rd   = trap_cause(w_pend_ent.load, 1'b1);
      w_upd.data = '0;
    end
  end

  frv_mem_fifo #(
    .DEPTH    (DEPTH),
    .W        (ENT_W),
    .KILL_BIT (KILL_BIT)
  ) u_fifo (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .i_push     (w_acc),
    .i_din      (w_din),
    .i_pop      (w_pop),
    .i_upd_en   (dmem_recv && w_pend_ok),
    .i_upd_idx  (w_pend_idx),
    .i_upd_data (w_upd),
    .i_kill_all (flush),
    .o_ents     (w_ents),
    .o_rptr     (w_rptr),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_head = lsu_ent_t'(w_ents[w_rptr[AW-1:0]]);

  assign s4_valid = !w_empty && w_head.done && !w_head.killed;
  assign w_pop    = !w_empty && w_head.done
                 && (w_head.killed || !s4_busy);
  assign s4_trap  = s4_valid && w_head.trap;
  assign s4_rd    = s4_valid ? w_head.rd : '0;
  assign s4_data  = s4_valid ? w_head.data : '0;

  assign w_unused = ^{w_head.load, w_head.sz,
                      w_head.sgn, w_head.lo};

  a_recv_pending: assert property (
    @(posedge g_clk) disable iff (!g_resetn)
    dmem_recv |-> w_pend_ok
  );

endmodule

// File: tb/tb_frv_mem_req_queue.sv
// Directed bench for frv_mem_req_queue:
// vector table for single ops plus multi-cycle sequences.
module tb_frv_mem_req_queue;

  logic        g_clk;
  logic        g_resetn;
  logic        flush;
  logic        hold_lsu_req;
  logic        s3_valid;
  logic        s3_busy;
  logic [4:0]  s3_rd;
  logic [31:0] s3_addr;
  logic [31:0] s3_wdata;
  logic        s3_load;
  logic        s3_store;
  logic [1:0]  s3_size;
  logic        s3_signed;
  logic        dmem_req;
  logic        dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_recv;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        mmio_en;
  logic        mmio_wen;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        s4_valid;
  logic        s4_busy;
  logic [4:0]  s4_rd;
  logic        s4_trap;
  logic [31:0] s4_data;

  int n_cmp = 0;
  int n_err = 0;

  frv_mem_req_queue dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .flush        (flush),
    .hold_lsu_req (hold_lsu_req),
    .s3_valid     (s3_valid),
    .s3_busy      (s3_busy),
    .s3_rd        (s3_rd),
    .s3_addr      (s3_addr),
    .s3_wdata     (s3_wdata),
    .s3_load      (s3_load),
    .s3_store     (s3_store),
    .s3_size      (s3_size),
    .s3_signed    (s3_signed),
    .dmem_req     (dmem_req),
    .dmem_wen     (dmem_wen),
    .dmem_strb    (dmem_strb),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_recv    (dmem_recv),
    .dmem_rdata   (dmem_rdata),
    .dmem_error   (dmem_error),
    .mmio_en      (mmio_en),
    .mmio_wen     (mmio_wen),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .s4_valid     (s4_valid),
    .s4_busy      (s4_busy),
    .s4_rd        (s4_rd),
    .s4_trap      (s4_trap),
    .s4_data      (s4_data)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ld;
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    logic        xreq;
    logic [3:0]  xstrb;
    logic [31:0] xwdata;
    logic        xmmio;
    logic        xtrap;
    logic [4:0]  xrd;
    logic [31:0] xdata;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge g_clk);
  endtask

  task automatic drv(input logic [31:0] a,
                     input logic ld,
                     input logic st,
                     input logic [1:0] sz,
                     input logic sg,
                     input logic [4:0] rd,
                     input logic [31:0] wd);
    s3_valid  = 1'b1;
    s3_addr   = a;
    s3_load   = ld;
    s3_store  = st;
    s3_size   = sz;
    s3_signed = sg;
    s3_rd     = rd;
    s3_wdata  = wd;
  endtask

  task automatic idle();
    s3_valid = 1'b0;
    s3_load  = 1'b0;
    s3_store = 1'b0;
  endtask

  task automatic recv(input logic [31:0] d,
                      input logic e);
    dmem_recv  = 1'b1;
    dmem_rdata = d;
    dmem_error = e;
  endtask

  task automatic norecv();
    dmem_recv  = 1'b0;
    dmem_error = 1'b0;
  endtask

  task automatic chk_s4(input string nm,
                        input logic t,
                        input logic [4:0] rd,
                        input logic [31:0] d);
    chk({nm, " s4_valid"}, s4_valid, 1);
    chk({nm, " s4_trap"}, s4_trap, t);
    chk({nm, " s4_rd"}, s4_rd, rd);
    chk({nm, " s4_data"}, s4_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tv[0]  = '{32'h2000, 32'h0, 1, 0, 2, 0, 3,
               32'hDEADBEEF, 0, 1, 4'hF, 32'h0,
               0, 0, 3, 32'hDEADBEEF};
    tv[1]  = '{32'h2003, 32'h0, 1, 0, 0, 1, 5,
               32'h80FFFFFF, 0, 1, 4'h8, 32'h0,
               0, 0, 5, 32'hFFFFFF80};
    tv[2]  = '{32'h2003, 32'h0, 1, 0, 0, 0, 6,
               32'h80FFFFFF, 0, 1, 4'h8, 32'h0,
               0, 0, 6, 32'h00000080};
    tv[3]  = '{32'h2001, 32'h1234, 0, 1, 1, 0, 9,
               32'h0, 0, 0, 4'h0, 32'h0,
               0, 1, 6, 32'h0};
    tv[4]  = '{32'h2002, 32'h0, 1, 0, 1, 1, 10,
               32'h80010000, 0, 1, 4'hC, 32'h0,
               0, 0, 10, 32'hFFFF8001};
    tv[5]  = '{32'h2002, 32'h0, 1, 0, 1, 0, 11,
               32'h80010000, 0, 1, 4'hC, 32'h0,
               0, 0, 11, 32'h00008001};
    tv[6]  = '{32'h2004, 32'hCAFEF00D, 0, 1, 2, 0, 0,
               32'h0, 0, 1, 4'hF, 32'hCAFEF00D,
               0, 0, 0, 32'h0};
    tv[7]  = '{32'h2005, 32'h000000A5, 0, 1, 0, 0, 0,
               32'h0, 0, 1, 4'h2, 32'hA5A5A5A5,
               0, 0, 0, 32'h0};
    tv[8]  = '{32'h2006, 32'h0000BEEF, 0, 1, 1, 0, 0,
               32'h0, 0, 1, 4'hC, 32'hBEEFBEEF,
               0, 0, 0, 32'h0};
    tv[9]  = '{32'h2002, 32'h0, 1, 0, 2, 0, 12,
               32'h0, 0, 0, 4'h0, 32'h0,
               0, 1, 4, 32'h0};
    tv[10] = '{32'h1004, 32'h55, 0, 1, 2, 0, 0,
               32'h0, 0, 0, 4'h0, 32'h0,
               1, 0, 0, 32'h0};
    tv[11] = '{32'h2008, 32'h0, 1, 0, 2, 0, 13,
               32'h12345678, 1, 1, 4'hF, 32'h0,
               0, 1, 5, 32'h0};
    tv[12] = '{32'h200C, 32'h1, 0, 1, 2, 0, 0,
               32'h0, 1, 1, 4'hF, 32'h1,
               0, 1, 7, 32'h0};
    tv[13] = '{32'h1FF0, 32'h0, 1, 0, 2, 0, 14,
               32'h0, 0, 0, 4'h0, 32'h0,
               1, 0, 14, 32'h0};

    g_resetn     = 1'b0;
    flush        = 1'b0;
    hold_lsu_req = 1'b0;
    s4_busy      = 1'b0;
    dmem_gnt     = 1'b0;
    dmem_rdata   = '0;
    s3_rd        = '0;
    s3_addr      = '0;
    s3_wdata     = '0;
    s3_size      = '0;
    s3_signed    = 1'b0;
    idle();
    norecv();
    repeat (3) cyc();
    g_resetn = 1'b1;
    mid();
    chk("rst s3_busy", s3_busy, 0);
    chk("rst s4_valid", s4_valid, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst mmio_en", mmio_en, 0);
    chk("rst s4_trap", s4_trap, 0);
    chk("rst s4_rd", s4_rd, 0);
    chk("rst s4_data", s4_data, 0);
    cyc();

    for (int i = 0; i < 14; i++) begin
      v = tv[i];
      drv(v.addr, v.ld, v.st, v.sz, v.sg, v.rd, v.wdata);
      dmem_gnt = 1'b1;
      mid();
      chk($sformatf("v%0d busy", i), s3_busy, 0);
      chk($sformatf("v%0d req", i), dmem_req, v.xreq);
      chk($sformatf("v%0d mmio_en", i), mmio_en, v.xmmio);
      if (v.xreq) begin
        chk($sformatf("v%0d strb", i), dmem_strb, v.xstrb);
        chk($sformatf("v%0d addr", i), dmem_addr,
            v.addr & ~32'h3);
        chk($sformatf("v%0d wen", i), dmem_wen, v.st);
        if (v.st)
          chk($sformatf("v%0d wdata", i), dmem_wdata,
              v.xwdata);
      end
      if (v.xmmio) begin
        chk($sformatf("v%0d mmio_wen", i), mmio_wen, v.st);
        chk($sformatf("v%0d mmio_addr", i), mmio_addr,
            v.addr);
        if (v.st)
          chk($sformatf("v%0d mmio_wdata", i), mmio_wdata,
              v.wdata);
      end
      cyc();
      idle();
      dmem_gnt = 1'b0;
      if (v.xreq) recv(v.rdata, v.err);
      mid();
      chk($sformatf("v%0d mmio_en off", i), mmio_en, 0);
      if (v.xreq)
        chk($sformatf("v%0d early s4", i), s4_valid, 0);
      else
        chk_s4($sformatf("v%0d", i), v.xtrap, v.xrd, v.xdata);
      cyc();
      norecv();
      if (v.xreq) begin
        mid();
        chk_s4($sformatf("v%0d", i), v.xtrap, v.xrd, v.xdata);
        cyc();
      end
      mid();
      chk($sformatf("v%0d drained", i), s4_valid, 0);
      cyc();
    end

    // hold_lsu_req blocks issue
    drv(32'h2000, 1, 0, 2, 0, 1, 32'h0);
    dmem_gnt     = 1'b1;
    hold_lsu_req = 1'b1;
    mid();
    chk("hold req", dmem_req, 0);
    chk("hold busy", s3_busy, 1);
    cyc();
    drv(32'h1000, 0, 1, 2, 0, 0, 32'h1);
    mid();
    chk("hold mmio_en", mmio_en, 0);
    cyc();
    hold_lsu_req = 1'b0;
    idle();
    dmem_gnt = 1'b0;
    mid();
    chk("hold nothing queued", s4_valid, 0);
    cyc();

    // DEPTH=2: third load stalls until first response
    dmem_gnt = 1'b1;
    drv(32'h2000, 1, 0, 2, 0, 1, 32'h0);
    mid();
    chk("q l1 busy", s3_busy, 0);
    cyc();
    drv(32'h2004, 1, 0, 2, 0, 2, 32'h0);
    mid();
    chk("q l2 busy", s3_busy, 0);
    cyc();
    drv(32'h2008, 1, 0, 2, 0, 3, 32'h0);
    mid();
    chk("q full busy", s3_busy, 1);
    chk("q full req", dmem_req, 0);
    cyc();
    recv(32'h11111111, 0);
    mid();
    chk("q recv1 busy", s3_busy, 1);
    cyc();
    norecv();
    mid();
    chk("q l3 req", dmem_req, 1);
    chk("q l3 busy", s3_busy, 0);
    chk("q l3 addr", dmem_addr, 32'h2008);
    chk_s4("q o1", 0, 1, 32'h11111111);
    cyc();
    idle();
    dmem_gnt = 1'b0;
    recv(32'h22222222, 0);
    mid();
    chk("q gap", s4_valid, 0);
    cyc();
    recv(32'h33333333, 0);
    s4_busy = 1'b1;
    mid();
    chk_s4("q o2", 0, 2, 32'h22222222);
    cyc();
    norecv();
    s4_busy = 1'b0;
    mid();
    chk_s4("q o2 stall", 0, 2, 32'h22222222);
    cyc();
    mid();
    chk_s4("q o3", 0, 3, 32'h33333333);
    cyc();
    mid();
    chk("q drained", s4_valid, 0);
    cyc();

    // trap behind a pending load completes in order
    dmem_gnt = 1'b1;
    drv(32'h2000, 1, 0, 2, 0, 8, 32'h0);
    cyc();
    drv(32'h2001, 0, 1, 1, 0, 0, 32'h0);
    mid();
    chk("ord trap busy", s3_busy, 0);
    chk("ord trap req", dmem_req, 0);
    chk("ord wait a", s4_valid, 0);
    cyc();
    idle();
    dmem_gnt = 1'b0;
    recv(32'hDEADBEEF, 0);
    mid();
    chk("ord wait b", s4_valid, 0);
    cyc();
    norecv();
    mid();
    chk_s4("ord ld", 0, 8, 32'hDEADBEEF);
    cyc();
    mid();
    chk_s4("ord trap", 1, 6, 32'h0);
    cyc();
    mid();
    chk("ord drained", s4_valid, 0);
    cyc();

    // flush with two loads in flight
    dmem_gnt = 1'b1;
    drv(32'h2000, 1, 0, 2, 0, 1, 32'h0);
    cyc();
    drv(32'h2004, 1, 0, 2, 0, 2, 32'h0);
    cyc();
    drv(32'h2008, 1, 0, 2, 0, 3, 32'h0);
    flush = 1'b1;
    recv(32'hAAAAAAAA, 0);
    mid();
    chk("fl busy", s3_busy, 1);
    chk("fl req", dmem_req, 0);
    cyc();
    idle();
    dmem_gnt = 1'b0;
    flush    = 1'b0;
    recv(32'hBBBBBBBB, 1);
    mid();
    chk("fl no s4 a", s4_valid, 0);
    cyc();
    norecv();
    mid();
    chk("fl no s4 b", s4_valid, 0);
    cyc();
    mid();
    chk("fl no s4 c", s4_valid, 0);
    chk("fl trap", s4_trap, 0);
    dmem_gnt = 1'b1;
    cyc();
    drv(32'h2010, 1, 0, 2, 0, 20, 32'h0);
    mid();
    chk("fl post1 busy", s3_busy, 0);
    cyc();
    drv(32'h2014, 1, 0, 2, 0, 21, 32'h0);
    mid();
    chk("fl post2 busy", s3_busy, 0);
    cyc();
    idle();
    dmem_gnt = 1'b0;
    recv(32'h00000077, 0);
    cyc();
    recv(32'h00000088, 0);
    mid();
    chk_s4("fl post1", 0, 20, 32'h00000077);
    cyc();
    norecv();
    mid();
    chk_s4("fl post2", 0, 21, 32'h00000088);
    cyc();
    mid();
    chk("fl drained", s4_valid, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
